// File: rtl/rv32_pkg.sv
// ============================================================================
//  Module      : rv32_pkg
//  Description : Shared RV32I opcodes, register indices and the
//                opcode-to-immediate-format mapping used by decode.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv32_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_R      = 7'b0110011;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_SP   = 5'd2;
  localparam logic [4:0] REG_GP   = 5'd3;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_fmt_e;

  function automatic imm_fmt_e imm_fmt(input logic [6:0] opcode);
    imm_fmt_e fmt;
    case (opcode)
      OP_LOAD, OP_IMM, OP_JALR: fmt = IMM_I;
      OP_STORE:                 fmt = IMM_S;
      OP_BRANCH:                fmt = IMM_B;
      OP_LUI, OP_AUIPC:         fmt = IMM_U;
      OP_JAL:                   fmt = IMM_J;
      default:                  fmt = IMM_NONE;
    endcase
    return fmt;
  endfunction

endpackage

`default_nettype wire

// File: rtl/imm_gen.sv
// ============================================================================
//  Module      : imm_gen
//  Description : Combinational RV32I immediate generator, sign-extended
//                from instruction[31]; zero for formats without an immediate.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imm_gen
  import rv32_pkg::*;
(
  input  logic [31:0] instruction,
  output logic [31:0] imm32
);

  logic        w_sign;
  logic [31:0] w_imm;

  assign w_sign = instruction[31];

  always_comb begin
    w_imm = '0;
    case (imm_fmt(instruction[6:0]))
      IMM_I: w_imm = {{20{w_sign}}, instruction[31:20]};
      IMM_S: w_imm = {{20{w_sign}}, instruction[31:25], instruction[11:7]};
      // Branch and jump offsets are byte offsets with an implied zero LSB.
      IMM_B: w_imm = {{19{w_sign}}, instruction[31], instruction[7],
                      instruction[30:25], instruction[11:8], 1'b0};
      IMM_U: w_imm = {instruction[31:12], 12'h000};
      IMM_J: w_imm = {{11{w_sign}}, instruction[31], instruction[19:12],
                      instruction[20], instruction[30:21], 1'b0};
      default: w_imm = '0;
    endcase
  end

  assign imm32 = w_imm;

endmodule

`default_nettype wire

// File: rtl/id_decoder.sv
// ============================================================================
//  Module      : id_decoder
//  Description : RV32I decode stage: 32x32 register file with two async read
//                ports, one sync write port and a debug read port; imm gen.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_decoder
  import rv32_pkg::*;
#(
  parameter logic [31:0] SP_INIT = 32'h0000_7FFC,
  parameter logic [31:0] GP_INIT = 32'h0000_1800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction,
  input  logic        regWrite,
  input  logic [31:0] writeData,
  output logic [31:0] rs1Data,
  output logic [31:0] rs2Data,
  output logic [31:0] imm32,
  output logic [4:0]  rdAddr,
  input  logic [4:0]  dbgAddr,
  output logic [31:0] dbgData
);

  logic [XLEN-1:0] r_regs [NREGS];

  logic [4:0] w_rs1;
  logic [4:0] w_rs2;
  logic [4:0] w_rd;

  assign w_rs1 = instruction[19:15];
  assign w_rs2 = instruction[24:20];
  assign w_rd  = instruction[11:7];

  // Reset takes priority over write-back, so a write in the reset cycle is lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
      r_regs[REG_SP] <= SP_INIT;
      r_regs[REG_GP] <= GP_INIT;
    end else if (regWrite && (w_rd != REG_ZERO)) begin
      r_regs[w_rd] <= writeData;
    end
  end

  // No write bypass: same-cycle reads return the pre-edge value.
  assign rs1Data = (w_rs1   == REG_ZERO) ? '0 : r_regs[w_rs1];
  assign rs2Data = (w_rs2   == REG_ZERO) ? '0 : r_regs[w_rs2];
  assign dbgData = (dbgAddr == REG_ZERO) ? '0 : r_regs[dbgAddr];
  assign rdAddr  = w_rd;

  imm_gen u_imm_gen (
    .instruction (instruction),
    .imm32       (imm32)
  );

endmodule

`default_nettype wire

// File: tb/tb_id_decoder.sv
// ============================================================================
//  Module      : tb_id_decoder
//  Description : Scoreboard bench for id_decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_id_decoder;

  localparam logic [31:0] c_sp_init = 32'h0000_7FFC;
  localparam logic [31:0] c_gp_init = 32'h0000_1800;

  logic        clk;
  logic        rst;
  logic [31:0] instruction;
  logic        regWrite;
  logic [31:0] writeData;
  logic [31:0] rs1Data;
  logic [31:0] rs2Data;
  logic [31:0] imm32;
  logic [4:0]  rdAddr;
  logic [4:0]  dbgAddr;
  logic [31:0] dbgData;

  id_decoder #(
    .SP_INIT (c_sp_init),
    .GP_INIT (c_gp_init)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .instruction (instruction),
    .regWrite    (regWrite),
    .writeData   (writeData),
    .rs1Data     (rs1Data),
    .rs2Data     (rs2Data),
    .imm32       (imm32),
    .rdAddr      (rdAddr),
    .dbgAddr     (dbgAddr),
    .dbgData     (dbgData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum logic [2:0] {S_RS1, S_RS2, S_IMM, S_RD, S_DBG} sel_e;
  typedef struct {
    string       tag;
    sel_e        sel;
    logic [31:0] exp;
  } exp_t;

  exp_t r_sb[$];
  int   r_errors = 0;
  int   r_checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    r_checks++;
    if (obs !== exp) begin
      r_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_val(input string tag, input sel_e sel, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    r_sb.push_back(e);
  endtask

  function automatic logic [31:0] observe(input sel_e sel);
    case (sel)
      S_RS1:   return rs1Data;
      S_RS2:   return rs2Data;
      S_IMM:   return imm32;
      S_RD:    return {27'd0, rdAddr};
      default: return dbgData;
    endcase
  endfunction

  // Let combinational outputs settle, then retire every queued expectation.
  task automatic drain();
    exp_t e;
    #1;
    while (r_sb.size() > 0) begin
      e = r_sb.pop_front();
      check(e.tag, observe(e.sel), e.exp);
    end
  endtask

  task automatic dbg_read(input string tag, input logic [4:0] addr, input logic [31:0] exp);
    dbgAddr = addr;
    expect_val(tag, S_DBG, exp);
    drain();
  endtask

  logic [31:0] imm_instr [7] = '{32'hFFF0_0093, 32'hFE20_AE23, 32'h0020_8263,
                                 32'hFE00_0EE3, 32'h1234_50B7, 32'h0080_00EF,
                                 32'h0020_80B3};
  logic [31:0] imm_exp   [7] = '{32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h0000_0004,
                                 32'hFFFF_FFFC, 32'h1234_5000, 32'h0000_0008,
                                 32'h0000_0000};

  initial begin
    rst         = 1'b1;
    instruction = '0;
    regWrite    = 1'b0;
    writeData   = '0;
    dbgAddr     = '0;

    // Reset contents
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    expect_val("rst_rs1", S_RS1, 32'h0);
    expect_val("rst_rs2", S_RS2, 32'h0);
    expect_val("rst_imm", S_IMM, 32'h0);
    drain();
    dbg_read("rst_x2", 5'd2, c_sp_init);
    dbg_read("rst_x3", 5'd3, c_gp_init);
    dbg_read("rst_x5", 5'd5, 32'h0);

    // addi x1,x0,5
    instruction = 32'h0050_0093;
    regWrite    = 1'b1;
    writeData   = 32'd5;
    dbgAddr     = 5'd1;
    expect_val("addi_rs1", S_RS1, 32'h0);
    expect_val("addi_imm", S_IMM, 32'd5);
    expect_val("addi_rd",  S_RD,  32'd1);
    expect_val("x1_pre",   S_DBG, 32'h0);
    drain();
    @(negedge clk);
    regWrite = 1'b0;
    expect_val("x1_post",  S_DBG, 32'd5);
    expect_val("addi_imm2", S_IMM, 32'd5);
    drain();

    // add x2,x1,x1
    instruction = 32'h0010_8133;
    expect_val("add_rs1", S_RS1, 32'd5);
    expect_val("add_rs2", S_RS2, 32'd5);
    expect_val("add_imm", S_IMM, 32'd0);
    expect_val("add_rd",  S_RD,  32'd2);
    drain();

    // addi x0,x0,7 must leave x0 at zero
    instruction = 32'h0070_0013;
    regWrite    = 1'b1;
    writeData   = 32'd7;
    expect_val("x0w_imm", S_IMM, 32'd7);
    drain();
    @(negedge clk);
    regWrite = 1'b0;
    expect_val("x0w_rs1", S_RS1, 32'h0);
    drain();
    dbg_read("x0w_dbg", 5'd0, 32'h0);

    // Immediate formats
    for (int i = 0; i < 7; i++) begin
      instruction = imm_instr[i];
      expect_val($sformatf("imm_%0d", i), S_IMM, imm_exp[i]);
      drain();
    end

    // add x1,x1,x1 : old value before the edge, new after
    instruction = 32'h0010_80B3;
    regWrite    = 1'b1;
    writeData   = 32'd10;
    expect_val("rw_rs1_pre", S_RS1, 32'd5);
    expect_val("rw_rs2_pre", S_RS2, 32'd5);
    drain();
    @(negedge clk);
    regWrite = 1'b0;
    expect_val("rw_rs1_post", S_RS1, 32'd10);
    expect_val("rw_rs2_post", S_RS2, 32'd10);
    drain();

    // x31 via rs2 port (highest index)
    instruction = 32'h0000_0FB3;  // add x31,x0,x0
    regWrite    = 1'b1;
    writeData   = 32'hA5A5_5A5A;
    @(negedge clk);
    regWrite    = 1'b0;
    instruction = 32'h01F0_0033;  // add x0,x0,x31
    expect_val("x31_rs2", S_RS2, 32'hA5A5_5A5A);
    drain();

    // x4 write, then reset with a concurrent write to x4
    instruction = 32'h0000_0213;  // addi x4,x0,0
    regWrite    = 1'b1;
    writeData   = 32'hDEAD_BEEF;
    @(negedge clk);
    regWrite = 1'b0;
    dbg_read("x4_set", 5'd4, 32'hDEAD_BEEF);
    rst       = 1'b1;
    regWrite  = 1'b1;
    writeData = 32'h1;
    @(negedge clk);
    rst      = 1'b0;
    regWrite = 1'b0;
    dbg_read("rst2_x4", 5'd4, 32'h0);
    dbg_read("rst2_x2", 5'd2, c_sp_init);
    dbg_read("rst2_x3", 5'd3, c_gp_init);
    dbg_read("rst2_x1", 5'd1, 32'h0);
    dbg_read("rst2_x31", 5'd31, 32'h0);

    $display("Result: errors=%0d of %0d checks", r_errors, r_checks);
    $finish;
  end

endmodule

`default_nettype wire
